imem_dmem_arbiter: RTL
======================

Name: imem_dmem_arbiter

Overview:
- Shares one external single-port memory between two requesters: the fetch stage (read-only) and the memory stage (read/write).
- Sequences every access through a request/acknowledge handshake and returns read data to the requester that owns the access.
- Drives per-requester stall signals so the pipeline freezes while its access is outstanding.
- Sits between the pipeline stages and the memory model or SRAM controller.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- if_req  in  1  fetch read request; held high until if_done.
- if_addr  in  ADDR_W  fetch byte address (the PC).
- if_rdata  out  DATA_W  fetched instruction; valid while if_done=1.
- if_done  out  1  one-cycle pulse; fetch access complete.
- if_stall  out  1  if_req & ~if_done (combinational).
- dm_req  in  1  data request; held high until dm_done.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data byte address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; valid while dm_done=1.
- dm_done  out  1  one-cycle pulse; data access complete.
- dm_stall  out  1  dm_req & ~dm_done (combinational).
- mem_req  out  1  request to memory; held high until mem_ack.
- mem_we  out  1  write enable to memory.
- mem_addr  out  ADDR_W  address to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_rdata  in  DATA_W  read data; valid in the cycle mem_ack=1.
- mem_ack  in  1  access complete; may arrive in the first mem_req cycle or any later cycle.

Behaviour:
- States: IDLE, BUSY_IF, BUSY_DM, DONE.
- Reset:
  - state=IDLE.
  - mem_req, mem_we, if_done, dm_done = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
- IDLE:
  - Arbitrate among the raised requests.
  - Default priority: dm_req wins over if_req, because the memory-stage access belongs to the older instruction.
  - On a grant, at the next edge: latch addr/we/wdata into the mem_* registers, set mem_req=1, go to BUSY_DM or BUSY_IF.
  - A fetch grant forces mem_we=0.
  - No request: stay in IDLE.
- BUSY_x:
  - mem_* outputs are registered and held constant while waiting.
  - If mem_ack=1 at an edge: capture mem_rdata into x_rdata, clear mem_req and mem_we, set x_done=1, go to DONE.
  - A write also pulses dm_done; dm_rdata is then unchanged.
- DONE:
  - x_done high for exactly this one cycle.
  - The requester drops or changes its req at this edge; the arbiter does not sample requests in DONE.
  - Next state is IDLE, with x_done=0.
  - x_rdata holds its value until the next capture.
- Latency:
  - Minimum three cycles from the IDLE grant edge to the return to IDLE, with ack in the first BUSY cycle.
  - Back-to-back accesses complete at most one per 3 cycles.
- Simultaneous if_req and dm_req in IDLE: serve DM first; IF waits with if_stall=1 and is granted at the next IDLE.
- Request changes while BUSY do not affect the in-flight access.
- A request dropped early is a protocol violation; behaviour is undefined and no checker is required.
- mem_ack outside BUSY is ignored.
- Reset mid-access:
  - Return immediately to IDLE, mem_req=0, pending done lost.
  - The memory must tolerate an abandoned request.

Optional Feature:
- Macro: FAIR_ARB_EN.
- Defined:
  - Add a 1-bit last_grant register, reset value = IF.
  - When both requests are present in IDLE, grant the requester that did not win last time.
  - Neither requester waits more than one foreign access.
- Undefined: fixed DM priority as described above.

Decomposition:
- Shared package mem_arb_pkg:
  - State encoding constants, 2 bits: IDLE=0, BUSY_IF=1, BUSY_DM=2, DONE=3.
  - Requester ID constants: REQ_IF=0, REQ_DM=1.
- Sub-module arb_select:
  - Combinational two-way priority pick.
  - Fixed or fair based on last_grant.
  - Outputs grant_if and grant_dm.
- Everything else stays in the top module.

Test Plan:
- Reset, then one fetch: if_req=1, if_addr=0x8, memory acks after 2 cycles with 0xDEADBEEF. Required: mem_addr=0x8 with mem_we=0; if_done pulses once; if_rdata=0xDEADBEEF; if_stall=0 in the done cycle.
- Simultaneous if_req (addr 0x4) and dm_req read (addr 0x100), ack in the first cycle. Required: DM is served first; IF is granted at the next IDLE; if_stall stays 1 through both accesses.
- DM write: dm_addr=0x20, dm_wdata=0x12345678. Required: mem_we=1 and mem_wdata held until ack; dm_done pulses; dm_rdata unchanged.
- rst asserted while in BUSY_IF with ack pending. Required: mem_req=0 and state IDLE immediately; no if_done pulse after reset release.
- Ack delay 0 vs 5 cycles. Required: mem_* outputs are stable throughout the wait; total latency is 3 cycles and 8 cycles respectively.
- FAIR_ARB_EN defined, both requests held continuously. Required: grants alternate DM, IF, DM, IF. Macro undefined, same stimulus: DM is granted every arbitration while dm_req stays high.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared constants and types for the IF/DM memory arbiter.
//            State encoding (2 bits) and requester identifiers.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_DM = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        BUSY_IF = ST_BUSY_IF,
        BUSY_DM = ST_BUSY_DM,
        DONE    = ST_DONE
    } state_t;

    // Requester identifiers, also the encoding of the last-grant register
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/imem_dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_dmem_arbiter_if
// Purpose  : Bundles the fetch port, data port and shared memory port of the
//            IF/DM arbiter.
//   slave  : arbiter view (pipeline requests and memory responses are inputs)
//   master : environment view (pipeline stages plus memory model)
// Revision : 1.0 - initial release
// ============================================================================
interface imem_dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              if_stall;
    // data port
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;
    logic              dm_stall;
    // memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/arb_select.sv
`default_nettype none
// ============================================================================
// Module   : arb_select
// Purpose  : Combinational two-way pick between fetch and data requests.
//   Ports  : req_if, req_dm   - raised requests
//            last_grant       - previous winner (REQ_IF / REQ_DM)
//            grant_if/dm      - one-hot (or zero) grant
// Config   : FAIR_ARB_EN defined   -> alternate on contention via last_grant
//            FAIR_ARB_EN undefined -> data request always wins
// Revision : 1.0 - initial release
// ============================================================================
module arb_select
    import mem_arb_pkg::*;
(
    input  logic req_if,
    input  logic req_dm,
    input  logic last_grant,
    output logic grant_if,
    output logic grant_dm
);

`ifdef FAIR_ARB_EN
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (req_if && req_dm) begin
            // Contention: hand the memory to whoever lost last time
            if (last_grant == REQ_IF) begin
                grant_dm = 1'b1;
            end else begin
                grant_if = 1'b1;
            end
        end else begin
            grant_if = req_if;
            grant_dm = req_dm;
        end
    end
`else
    // The memory-stage access belongs to the older instruction, so it wins
    logic w_unused_last_grant;
    assign w_unused_last_grant = last_grant;
    assign grant_dm            = req_dm;
    assign grant_if            = req_if & ~req_dm;
`endif

endmodule
`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_dmem_arbiter
// Purpose  : Shares one single-port memory between the fetch stage (read
//            only) and the memory stage (read/write). Each access runs
//            IDLE -> BUSY_x -> DONE -> IDLE; memory outputs are registered
//            and held until mem_ack.
//   Ports  : clk, rst (asynchronous, active-high)
//            bus (imem_dmem_arbiter_if.slave) - fetch, data and memory ports
// Config   : FAIR_ARB_EN - alternate grants on contention (adds last_grant)
// Revision : 1.0 - initial release
// ============================================================================
module imem_dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    imem_dmem_arbiter_if.slave   bus
);

    state_t              r_state,     w_state_nxt;
    logic                r_mem_req,   w_mem_req_nxt;
    logic                r_mem_we,    w_mem_we_nxt;
    logic [ADDR_W-1:0]   r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0]   r_if_rdata,  w_if_rdata_nxt;
    logic [DATA_W-1:0]   r_dm_rdata,  w_dm_rdata_nxt;
    logic                r_if_done,   w_if_done_nxt;
    logic                r_dm_done,   w_dm_done_nxt;

    logic                w_grant_if;
    logic                w_grant_dm;
    logic                w_last_grant;

    arb_select u_arb_select (
        .req_if     (bus.if_req),
        .req_dm     (bus.dm_req),
        .last_grant (w_last_grant),
        .grant_if   (w_grant_if),
        .grant_dm   (w_grant_dm)
    );

`ifdef FAIR_ARB_EN
    logic r_last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= REQ_IF;
        end else if (r_state == IDLE) begin
            if (w_grant_dm) begin
                r_last_grant <= REQ_DM;
            end else if (w_grant_if) begin
                r_last_grant <= REQ_IF;
            end
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = REQ_IF;
`endif

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_dm_rdata_nxt  = r_dm_rdata;
        w_if_done_nxt   = 1'b0;
        w_dm_done_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_grant_dm) begin
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = bus.dm_we;
                    w_mem_addr_nxt  = bus.dm_addr;
                    w_mem_wdata_nxt = bus.dm_wdata;
                    w_state_nxt     = BUSY_DM;
                end else if (w_grant_if) begin
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = bus.if_addr;
                    w_state_nxt     = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (bus.mem_ack) begin
                    w_if_rdata_nxt = bus.mem_rdata;
                    w_mem_req_nxt  = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_if_done_nxt  = 1'b1;
                    w_state_nxt    = DONE;
                end
            end
            BUSY_DM: begin
                if (bus.mem_ack) begin
                    // A store completes without disturbing the last load value
                    if (!r_mem_we) begin
                        w_dm_rdata_nxt = bus.mem_rdata;
                    end
                    w_mem_req_nxt = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                    w_dm_done_nxt = 1'b1;
                    w_state_nxt   = DONE;
                end
            end
            // Requests are not sampled here: the requester is updating them
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_done   <= 1'b0;
            r_dm_done   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_dm_rdata  <= w_dm_rdata_nxt;
            r_if_done   <= w_if_done_nxt;
            r_dm_done   <= w_dm_done_nxt;
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.if_done   = r_if_done;
    assign bus.dm_done   = r_dm_done;
    assign bus.if_stall  = bus.if_req & ~r_if_done;
    assign bus.dm_stall  = bus.dm_req & ~r_dm_done;

endmodule
`default_nettype wire
